// File: rtl/battleship_pkg.sv
// Shared definitions for the battleship game sequencer: cell codes,
// one-hot game states, default grid size and button slot indices.
package battleship_pkg;

  localparam int DEF_GRID_W = 10;
  localparam int DEF_GRID_H = 10;

  localparam logic [3:0] CELL_EMPTY = 4'b0000;
  localparam logic [3:0] CELL_SHIP  = 4'b0001;
  localparam logic [3:0] CELL_MISS  = 4'b0010;
  localparam logic [3:0] CELL_HIT   = 4'b0011;

  localparam logic [4:0] GS_IDLE = 5'b00001;
  localparam logic [4:0] GS_AIM  = 5'b00010;
  localparam logic [4:0] GS_FIRE = 5'b00100;
  localparam logic [4:0] GS_WIN  = 5'b01000;
  localparam logic [4:0] GS_LOSE = 5'b10000;

  typedef enum logic [4:0] {
    ST_IDLE = GS_IDLE,
    ST_AIM  = GS_AIM,
    ST_FIRE = GS_FIRE,
    ST_WIN  = GS_WIN,
    ST_LOSE = GS_LOSE
  } state_e;

  // Bit positions of each button inside the edge-detector vector.
  localparam int B_START  = 0;
  localparam int B_RESET  = 1;
  localparam int B_UP     = 2;
  localparam int B_DOWN   = 3;
  localparam int B_LEFT   = 4;
  localparam int B_RIGHT  = 5;
  localparam int B_SELECT = 6;
  localparam int NUM_BTN  = 7;

  // A cell that was already shot at (repeat shot, nothing to update).
  function automatic logic cell_already_shot(input logic [3:0] code);
    return (code == CELL_MISS) || (code == CELL_HIT);
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Registered rising-edge detector for one debounced button level.
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic rise_o
);

  logic prev_q;

  // Remember last cycle's level so only 0->1 transitions register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev_q <= 1'b0;
    else       prev_q <= btn_i;
  end

  assign rise_o = btn_i & ~prev_q;

endmodule

// File: rtl/battleship_game_ctrl.sv
// Battleship game sequencer: cursor movement, shot read/modify/write
// handshake with the board store, and turn / ship-cell bookkeeping.
module battleship_game_ctrl
  import battleship_pkg::*;
#(
  parameter int GRID_W     = DEF_GRID_W,
  parameter int GRID_H     = DEF_GRID_H,
  parameter int MAX_TURNS  = 50,
  parameter int SHIP_CELLS = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_btn,
  input  logic       reset_btn,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_select,
  output logic [6:0] brd_addr,
  output logic       brd_rd_req,
  input  logic       brd_rd_ack,
  input  logic [3:0] brd_rd_data,
  output logic       brd_wr_en,
  output logic [3:0] brd_wr_data,
  output logic       brd_init,
  output logic [6:0] selected_cell,
  output logic [7:0] turns_remaining,
  output logic [6:0] ships_remaining,
  output logic [4:0] game_state,
  output logic       shot_select,
  output logic       hit_detected
);

  localparam int ROW_W = (GRID_H > 1) ? $clog2(GRID_H) : 1;
  localparam int COL_W = (GRID_W > 1) ? $clog2(GRID_W) : 1;
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(GRID_H - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(GRID_W - 1);
  localparam logic [7:0] TURNS_INIT = 8'(MAX_TURNS);
  localparam logic [6:0] SHIPS_INIT = 7'(SHIP_CELLS);

  logic [NUM_BTN-1:0] btn_lvl, btn_rise;

  assign btn_lvl[B_START]  = start_btn;
  assign btn_lvl[B_RESET]  = reset_btn;
  assign btn_lvl[B_UP]     = btn_up;
  assign btn_lvl[B_DOWN]   = btn_down;
  assign btn_lvl[B_LEFT]   = btn_left;
  assign btn_lvl[B_RIGHT]  = btn_right;
  assign btn_lvl[B_SELECT] = btn_select;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_edge
    btn_edge u_edge (
      .clk   (clk),
      .reset (reset),
      .btn_i (btn_lvl[i]),
      .rise_o(btn_rise[i])
    );
  end

  state_e           state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [7:0]       turns_q, turns_d;
  logic [6:0]       ships_q, ships_d;
  logic [6:0]       addr_q, addr_d;
  logic [3:0]       wr_data_q, wr_data_d;
  logic             rd_req_q, rd_req_d;
  logic             wr_en_q, wr_en_d;
  logic             init_q, init_d;
  logic             shot_q, shot_d;
  logic             hit_q, hit_d;

  logic [6:0] cursor_idx;
  logic [7:0] turns_dec;
  logic [6:0] ships_dec;

  assign cursor_idx = 7'(row_q) * 7'(GRID_W) + 7'(col_q);
  // Saturating decrements: counters stop at zero.
  assign turns_dec  = (turns_q != 8'd0) ? turns_q - 8'd1 : turns_q;
  assign ships_dec  = (ships_q != 7'd0) ? ships_q - 7'd1 : ships_q;

  // Next-state, cursor, counter and strobe logic for the game FSM.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    turns_d   = turns_q;
    ships_d   = ships_q;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    rd_req_d  = rd_req_q;
    wr_en_d   = 1'b0;
    init_d    = 1'b0;
    shot_d    = 1'b0;
    hit_d     = 1'b0;

    if (btn_rise[B_RESET]) begin
      // Abandons any in-flight read; a late ack lands in IDLE and is ignored.
      state_d  = ST_IDLE;
      row_d    = '0;
      col_d    = '0;
      turns_d  = '0;
      ships_d  = '0;
      rd_req_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_WIN, ST_LOSE: begin
          if (btn_rise[B_START]) begin
            state_d = ST_AIM;
            init_d  = 1'b1;
            turns_d = TURNS_INIT;
            ships_d = SHIPS_INIT;
            row_d   = '0;
            col_d   = '0;
          end
        end
        ST_AIM: begin
          if (btn_rise[B_SELECT]) begin
            state_d  = ST_FIRE;
            shot_d   = 1'b1;
            rd_req_d = 1'b1;
            addr_d   = cursor_idx;
          end else if (btn_rise[B_UP]) begin
            if (row_q != '0) row_d = row_q - 1'b1;
          end else if (btn_rise[B_DOWN]) begin
            if (row_q < ROW_LAST) row_d = row_q + 1'b1;
          end else if (btn_rise[B_LEFT]) begin
            if (col_q != '0) col_d = col_q - 1'b1;
          end else if (btn_rise[B_RIGHT]) begin
            if (col_q < COL_LAST) col_d = col_q + 1'b1;
          end
        end
        ST_FIRE: begin
          if (brd_rd_ack) begin
            rd_req_d = 1'b0;
            if (cell_already_shot(brd_rd_data)) begin
              state_d = ST_AIM;
            end else begin
              wr_en_d = 1'b1;
              turns_d = turns_dec;
              if (brd_rd_data == CELL_SHIP) begin
                wr_data_d = CELL_HIT;
                hit_d     = 1'b1;
                ships_d   = ships_dec;
              end else begin
                wr_data_d = CELL_MISS;
              end
              // Sinking the last cell wins even on the final turn.
              if (ships_d == 7'd0)      state_d = ST_WIN;
              else if (turns_d == 8'd0) state_d = ST_LOSE;
              else                      state_d = ST_AIM;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, cursor, counters and board-interface registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      row_q     <= '0;
      col_q     <= '0;
      turns_q   <= '0;
      ships_q   <= '0;
      addr_q    <= '0;
      wr_data_q <= '0;
      rd_req_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      init_q    <= 1'b0;
      shot_q    <= 1'b0;
      hit_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      turns_q   <= turns_d;
      ships_q   <= ships_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      rd_req_q  <= rd_req_d;
      wr_en_q   <= wr_en_d;
      init_q    <= init_d;
      shot_q    <= shot_d;
      hit_q     <= hit_d;
    end
  end

  assign brd_addr        = addr_q;
  assign brd_rd_req      = rd_req_q;
  assign brd_wr_en       = wr_en_q;
  assign brd_wr_data     = wr_data_q;
  assign brd_init        = init_q;
  assign selected_cell   = cursor_idx;
  assign turns_remaining = turns_q;
  assign ships_remaining = ships_q;
  assign game_state      = state_q;
  assign shot_select     = shot_q;
  assign hit_detected    = hit_q;

endmodule
